// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and FSM type for the K=3 convolutional encoder/decoder pair
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;
  localparam int TAIL_LEN   = K - 1;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_fsm_e;

endpackage

// File: rtl/conv_enc_core.sv
// rtl/conv_enc_core.sv - combinational K=3 encoder step: (in, s) -> {symbol, next state}
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic       in_bit,
  input  logic [1:0] state,
  output logic [1:0] sym,
  output logic [1:0] next_state
);

  logic [2:0] taps;

  assign taps       = {in_bit, state};
  assign sym        = {^(G0 & taps), ^(G1 & taps)};
  assign next_state = {in_bit, state[1]};

endmodule

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - framed rate-1/2 K=3 encoder with zero tail; optional CONV_ENC_ERR_INJ_EN adds i_err_mask
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int         FRAME_LEN = 8,
  parameter logic [2:0] G0        = G0_DEF,
  parameter logic [2:0] G1        = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_bit,
  input  logic       i_valid,
`ifdef CONV_ENC_ERR_INJ_EN
  input  logic [1:0] i_err_mask,
`endif
  output logic       o_ready,
  output logic [1:0] o_sym,
  output logic       o_sym_valid,
  input  logic       i_sym_ready,
  output logic [1:0] o_state,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  enc_fsm_e      fsm_q;
  logic [1:0]    s_q;
  logic [CW-1:0] count_q;
  logic          tail_cnt_q;
  logic [1:0]    sym_q;
  logic          sym_valid_q;
  logic          done_q;

  logic          slot_free;
  logic          core_in;
  logic [1:0]    core_sym;
  logic [1:0]    core_next;
  logic [1:0]    err_mask;
  logic [1:0]    sym_d;

  // A new symbol may load in the same cycle the held one is taken downstream.
  assign slot_free = !sym_valid_q || i_sym_ready;
  assign core_in   = (fsm_q == ENC) ? i_bit : 1'b0;

`ifdef CONV_ENC_ERR_INJ_EN
  assign err_mask = i_err_mask;
`else
  assign err_mask = 2'b00;
`endif

  assign sym_d = core_sym ^ err_mask;

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .in_bit     (core_in),
    .state      (s_q),
    .sym        (core_sym),
    .next_state (core_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      s_q         <= ST_00;
      count_q     <= '0;
      tail_cnt_q  <= 1'b0;
      sym_q       <= 2'b00;
      sym_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sym_valid_q && i_sym_ready) sym_valid_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (i_start) begin
            s_q        <= ST_00;
            count_q    <= '0;
            tail_cnt_q <= 1'b0;
            fsm_q      <= ENC;
          end
        end
        ENC: begin
          if (i_valid && slot_free) begin
            sym_q       <= sym_d;
            sym_valid_q <= 1'b1;
            s_q         <= core_next;
            count_q     <= count_q + CW'(1);
            if (count_q == LAST_BIT) fsm_q <= TAIL;
          end
        end
        TAIL: begin
          // Two zero-input steps flush the register back to state 00.
          if (slot_free) begin
            sym_q       <= sym_d;
            sym_valid_q <= 1'b1;
            s_q         <= core_next;
            tail_cnt_q  <= 1'b1;
            if (tail_cnt_q) fsm_q <= DONE;
          end
        end
        DONE: begin
          if (sym_valid_q && i_sym_ready) begin
            done_q <= 1'b1;
            fsm_q  <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (fsm_q == ENC) && slot_free;
  assign o_sym       = sym_q;
  assign o_sym_valid = sym_valid_q;
  assign o_state     = s_q;
  assign o_busy      = (fsm_q != IDLE);
  assign o_done      = done_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - randomized self-checking bench for conv_encoder against a sliding-window code model
module tb_conv_encoder;

  localparam int FRAME_LEN = 8;
  localparam int NSYM      = FRAME_LEN + 2;
`ifdef CONV_ENC_ERR_INJ_EN
  localparam bit ERR_INJ = 1'b1;
`else
  localparam bit ERR_INJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic       i_bit = 1'b0;
  logic       i_valid = 1'b0;
  logic [1:0] err_mask = 2'b00;
  logic       o_ready;
  logic [1:0] o_sym;
  logic       o_sym_valid;
  logic       i_sym_ready = 1'b1;
  logic [1:0] o_state;
  logic       o_busy;
  logic       o_done;

  conv_encoder #(.FRAME_LEN(FRAME_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_bit       (i_bit),
    .i_valid     (i_valid),
`ifdef CONV_ENC_ERR_INJ_EN
    .i_err_mask  (err_mask),
`endif
    .o_ready     (o_ready),
    .o_sym       (o_sym),
    .o_sym_valid (o_sym_valid),
    .i_sym_ready (i_sym_ready),
    .o_state     (o_state),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  int         done_cnt = 0;
  int         bp_viol = 0;
  int         rdy_viol = 0;
  int         ready_mode = 0;
  logic       prev_hold = 1'b0;
  logic [1:0] prev_sym = 2'b00;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!o_sym_valid || o_sym !== prev_sym)) bp_viol++;
      if (o_sym_valid && !i_sym_ready && o_ready) rdy_viol++;
      if (o_sym_valid && i_sym_ready) got_q.push_back(o_sym);
      if (o_done) done_cnt++;
      prev_hold = o_sym_valid && !i_sym_ready;
      prev_sym  = o_sym;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       i_sym_ready = 1'b1;
      1:       i_sym_ready = ~i_sym_ready;
      default: i_sym_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic int bitat(input logic [FRAME_LEN-1:0] m, input int i);
    if (i < 0 || i >= FRAME_LEN) return 0;
    return int'(m[i]);
  endfunction

  // Code bits from the last three inputs of the zero-padded message stream.
  task automatic build_exp(input logic [FRAME_LEN-1:0] msg, input int err_idx, input logic [1:0] err_m);
    int u0, u1, u2;
    logic [1:0] s;
    exp_q.delete();
    for (int t = 0; t < NSYM; t++) begin
      u0 = bitat(msg, t);
      u1 = bitat(msg, t - 1);
      u2 = bitat(msg, t - 2);
      s  = {1'((u0 + u1 + u2) % 2), 1'((u0 + u2) % 2)};
      if (ERR_INJ && t == err_idx) s = s ^ err_m;
      exp_q.push_back(s);
    end
  endtask

  task automatic feed(input logic [FRAME_LEN-1:0] msg, input int nbits, input int err_idx,
                      input logic [1:0] err_m, input bit junk);
    int guard;
    bit acc;
    for (int i = 0; i < nbits; i++) begin
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        i_bit    = msg[i];
        i_valid  = ($urandom_range(0, 3) != 0);
        err_mask = (i == err_idx) ? err_m : 2'b00;
        i_start  = junk && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        acc = i_valid && o_ready;
        @(posedge clk);
        #1;
        guard++;
        if (guard > 200) begin
          chk("feed_timeout", 1, 0);
          i_valid = 1'b0; i_start = 1'b0; err_mask = 2'b00;
          return;
        end
      end
    end
    i_valid  = 1'b0;
    i_start  = 1'b0;
    err_mask = 2'b00;
  endtask

  task automatic run_frame(input string name, input logic [FRAME_LEN-1:0] msg, input int mode,
                           input bit junk, input int err_idx, input logic [1:0] err_m);
    int g;
    ready_mode = mode;
    got_q.delete();
    done_cnt = 0; bp_viol = 0; rdy_viol = 0;
    if (junk) begin
      i_valid = 1'b1;
      repeat (3) begin i_bit = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
      i_valid = 1'b0;
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    feed(msg, FRAME_LEN, err_idx, err_m, junk);
    if (junk) i_valid = 1'b1;
    g = 0;
    while (done_cnt == 0 && g < 300) begin
      if (junk) i_bit = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      g++;
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    build_exp(msg, err_idx, err_m);
    chk({name, "_nsym"}, got_q.size(), NSYM);
    for (int i = 0; i < NSYM; i++)
      if (i < got_q.size()) chk($sformatf("%s_sym%0d", name, i), got_q[i], exp_q[i]);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_state"}, o_state, 2'b00);
    chk({name, "_busy"}, o_busy, 1'b0);
    chk({name, "_hold"}, bp_viol, 0);
    chk({name, "_rdy"}, rdy_viol, 0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_sym"}, o_sym, 2'b00);
    chk({name, "_valid"}, o_sym_valid, 1'b0);
    chk({name, "_ready"}, o_ready, 1'b0);
    chk({name, "_state"}, o_state, 2'b00);
    chk({name, "_busy"}, o_busy, 1'b0);
    chk({name, "_done"}, o_done, 1'b0);
  endtask

  logic [1:0] spec_seq [NSYM] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
  logic [FRAME_LEN-1:0] ref_msg = 8'h4D;

  initial begin
    logic [FRAME_LEN-1:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame("ref", ref_msg, 0, 1'b0, -1, 2'b00);
    for (int i = 0; i < NSYM; i++)
      if (i < got_q.size()) chk($sformatf("ref_lit%0d", i), got_q[i], spec_seq[i]);

    run_frame("bp", ref_msg, 1, 1'b0, -1, 2'b00);
    run_frame("junk", ref_msg, 0, 1'b1, -1, 2'b00);
    if (ERR_INJ) run_frame("err", ref_msg, 0, 1'b0, 2, 2'b01);

    for (int f = 0; f < 6; f++) begin
      m = FRAME_LEN'($urandom);
      run_frame($sformatf("rnd%0d", f), m, 2, 1'b1, int'($urandom_range(0, FRAME_LEN - 1)),
                2'($urandom_range(0, 3)));
    end

    ready_mode = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    feed(FRAME_LEN'($urandom), 4, -1, 2'b00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame("zero", '0, 0, 1'b0, -1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
